// File: rtl/acs_k3.sv
// Radix-2 add-compare-select for the K=3 (7,5) code, four states, no metric normalisation.
// Latency 1 cycle, one symbol pair per cycle, no backpressure; idle cycles hold state.
module acs_k3 #(
  parameter int W_PM     = 12,
  parameter int INIT_PEN = 512
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic signed [7:0]      r0_p2,
  input  logic signed [7:0]      r0_m2,
  input  logic signed [7:0]      r1_p2,
  input  logic signed [7:0]      r1_m2,
  output logic                   out_valid,
  output logic [3:0]             dec,
  output logic [4*W_PM-1:0]      pm,
  output logic [1:0]             best_state
);

  localparam logic [W_PM-1:0] PEN_NEG = W_PM'(-INIT_PEN);

  logic [W_PM-1:0] r_pm [4];
  logic [3:0]      r_dec;
  logic [1:0]      r_best;
  logic            r_vld;

  logic [W_PM-1:0] w_cur [4];
  logic [W_PM-1:0] w_new [4];
  logic [3:0]      w_dec;
  logic            w_s01, w_s23, w_sf;
  logic [1:0]      w_i01, w_i23, w_best;

  function automatic logic signed [8:0] f_bm(input logic c0, input logic c1,
                                             input logic signed [7:0] a0p, input logic signed [7:0] a0m,
                                             input logic signed [7:0] a1p, input logic signed [7:0] a1m);
    logic [7:0] s0, s1;
    s0 = c0 ? a0m : a0p;
    s1 = c1 ? a1m : a1p;
    return {s0[7], s0} + {s1[7], s1};
  endfunction

  // True when y beats x under modulo-2^W_PM comparison (strictly greater).
  function automatic logic f_gt(input logic [W_PM-1:0] x, input logic [W_PM-1:0] y);
    logic [W_PM-1:0] d;
    d = y - x;
    return ~d[W_PM-1] & (|d);
  endfunction

  for (genvar n = 0; n < 4; n++) begin : g_acs
    localparam logic U  = 1'(n / 2);
    localparam logic A  = 1'(n % 2);
    localparam int   I0 = 2 * (n % 2);
    logic signed [8:0] w_bm0, w_bm1;
    logic [W_PM-1:0]   w_p0, w_p1;
    logic              w_sel;

    assign w_cur[n] = start ? ((n == 0) ? '0 : PEN_NEG) : r_pm[n];
    // Predecessor {a,0} has b=0, predecessor {a,1} has b=1.
    assign w_bm0    = f_bm(U ^ A, U, r0_p2, r0_m2, r1_p2, r1_m2);
    assign w_bm1    = f_bm(~(U ^ A), ~U, r0_p2, r0_m2, r1_p2, r1_m2);
    assign w_p0     = w_cur[I0] + {{(W_PM-9){w_bm0[8]}}, w_bm0};
    assign w_p1     = w_cur[I0+1] + {{(W_PM-9){w_bm1[8]}}, w_bm1};
    assign w_sel    = f_gt(w_p0, w_p1);
    assign w_dec[n] = w_sel;
    assign w_new[n] = w_sel ? w_p1 : w_p0;
    assign pm[n*W_PM +: W_PM] = r_pm[n];
  end

  assign w_s01  = f_gt(w_new[0], w_new[1]);
  assign w_s23  = f_gt(w_new[2], w_new[3]);
  assign w_i01  = {1'b0, w_s01};
  assign w_i23  = {1'b1, w_s23};
  assign w_sf   = f_gt(w_new[w_i01], w_new[w_i23]);
  assign w_best = w_sf ? w_i23 : w_i01;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 4; n++) r_pm[n] <= (n == 0) ? '0 : PEN_NEG;
      r_dec  <= '0;
      r_best <= '0;
      r_vld  <= 1'b0;
    end else if (in_valid) begin
      for (int n = 0; n < 4; n++) r_pm[n] <= w_new[n];
      r_dec  <= w_dec;
      r_best <= w_best;
      r_vld  <= 1'b1;
    end else begin
      r_vld <= 1'b0;
      if (start) begin
        for (int n = 0; n < 4; n++) r_pm[n] <= (n == 0) ? '0 : PEN_NEG;
        r_dec  <= '0;
        r_best <= '0;
      end
    end
  end

  assign out_valid  = r_vld;
  assign dec        = r_dec;
  assign best_state = r_best;

endmodule

// File: tb/tb_acs_k3.sv
// Scoreboard bench for acs_k3: stimulus pushes expectations from an exact-integer Viterbi model.
module tb_acs_k3;
  localparam int W    = 12;
  localparam int INIT = 512;
  localparam logic [4*W-1:0] PM_INIT = {12'hE00, 12'hE00, 12'hE00, 12'h000};
  localparam logic [4*W-1:0] PM_R25  = {12'hE00, 12'hF38, 12'hE00, 12'h0C8};

  logic clk = 1'b0;
  logic rst_n, start, in_valid;
  logic signed [7:0] r0_p2, r0_m2, r1_p2, r1_m2;
  logic out_valid;
  logic [3:0] dec;
  logic [4*W-1:0] pm;
  logic [1:0] best_state;

  always #5 clk = ~clk;

  acs_k3 #(.W_PM(W), .INIT_PEN(INIT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .r0_p2(r0_p2), .r0_m2(r0_m2), .r1_p2(r1_p2), .r1_m2(r1_m2),
    .out_valid(out_valid), .dec(dec), .pm(pm), .best_state(best_state)
  );

  typedef struct {
    logic [4*W-1:0] pm;
    logic [3:0]     dec;
    logic [1:0]     best;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  longint     m_pm[4];
  logic [3:0] m_dec;
  logic [1:0] m_best;

  task automatic chk(input string name, input logic [4*W-1:0] act, input logic [4*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4*W-1:0] pack_model();
    logic [4*W-1:0] v;
    for (int i = 0; i < 4; i++) v[i*W +: W] = m_pm[i][W-1:0];
    return v;
  endfunction

  task automatic model_init();
    m_pm[0] = 0;
    for (int i = 1; i < 4; i++) m_pm[i] = -INIT;
    m_dec  = 4'b0;
    m_best = 2'd0;
  endtask

  // Exact trellis step: walk each source state and input bit, then pick survivors.
  task automatic model_step(input bit st, input longint p0, input longint n0,
                            input longint p1, input longint n1);
    longint src[4];
    longint cand[4][2];
    longint nw[4];
    int a, b, c0, c1, ns;
    longint bm;
    for (int s = 0; s < 4; s++) src[s] = st ? ((s == 0) ? 0 : -INIT) : m_pm[s];
    for (int s = 0; s < 4; s++) begin
      a = s / 2;
      b = s % 2;
      for (int u = 0; u < 2; u++) begin
        c0 = u ^ a ^ b;
        c1 = u ^ b;
        bm = (c0 != 0 ? n0 : p0) + (c1 != 0 ? n1 : p1);
        ns = u * 2 + a;
        cand[ns][b] = src[s] + bm;
      end
    end
    for (int i = 0; i < 4; i++) begin
      m_dec[i] = (cand[i][1] > cand[i][0]);
      nw[i]    = m_dec[i] ? cand[i][1] : cand[i][0];
    end
    m_best = 2'd0;
    for (int i = 1; i < 4; i++) if (nw[i] > nw[m_best]) m_best = 2'(i);
    for (int i = 0; i < 4; i++) m_pm[i] = nw[i];
  endtask

  task automatic push_exp();
    exp_t e;
    e.pm   = pack_model();
    e.dec  = m_dec;
    e.best = m_best;
    q.push_back(e);
  endtask

  task automatic sym(input bit st, input logic signed [7:0] a, input logic signed [7:0] b,
                     input logic signed [7:0] c, input logic signed [7:0] d);
    start    = st;
    in_valid = 1'b1;
    r0_p2 = a; r0_m2 = b; r1_p2 = c; r1_m2 = d;
    model_step(st, a, b, c, d);
    push_exp();
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic symx(input bit st, input int x0, input int x1);
    sym(st, 8'(2 * x0), 8'(-2 * x0), 8'(2 * x1), 8'(-2 * x1));
  endtask

  task automatic idle(input bit st);
    start    = st;
    in_valid = 1'b0;
    if (st) model_init();
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("idle_vld", out_valid, 1'b0);
    chk("idle_pm", pm, pack_model());
    chk("idle_dec", dec, m_dec);
    chk("idle_best", best_state, m_best);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: out_valid=1 with no expected entry at %0t", $time);
      end else begin
        e = q.pop_front();
        chk("sb_pm", pm, e.pm);
        chk("sb_dec", dec, e.dec);
        chk("sb_best", best_state, e.best);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
    r0_p2 = '0; r0_m2 = '0; r1_p2 = '0; r1_m2 = '0;
    model_init();
    #12;
    chk("rst_vld", out_valid, 1'b0);
    chk("rst_pm", pm, PM_INIT);
    chk("rst_dec", dec, 4'b0);
    chk("rst_best", best_state, 2'd0);
    #5 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // First symbol with start: hand-computed result.
    sym(1'b1, 8'sd100, -8'sd100, 8'sd100, -8'sd100);
    chk("r25_vld", out_valid, 1'b1);
    chk("r25_pm", pm, PM_R25);
    chk("r25_dec", dec, 4'b0000);
    chk("r25_best", best_state, 2'd0);

    // Same symbol for 200 cycles in total: state 0 gains 200 per step and wraps.
    for (int i = 0; i < 199; i++) begin
      sym(1'b0, 8'sd100, -8'sd100, 8'sd100, -8'sd100);
      chk("hold_dec0", dec[0], 1'b0);
      chk("hold_best", best_state, 2'd0);
    end
    chk("wrap_pm0", pm[W-1:0], 12'hC40);

    // Mixed stream with a 3-cycle gap, then resume from held metrics.
    symx(1'b0, -30, 20);
    symx(1'b0, 15, -40);
    symx(1'b0, -5, -25);
    idle(1'b0);
    idle(1'b0);
    idle(1'b0);
    symx(1'b0, 35, 10);
    symx(1'b0, -20, 40);

    // Start alone reloads, then all-zero products tie everywhere.
    idle(1'b1);
    chk("start_pm", pm, PM_INIT);
    for (int i = 0; i < 6; i++) begin
      sym(1'b0, 8'sd0, 8'sd0, 8'sd0, 8'sd0);
      chk("zero_dec", dec, 4'b0000);
      chk("zero_best", best_state, 2'd0);
    end

    // Asynchronous reset pulse while a symbol is in flight.
    symx(1'b1, 25, -10);
    symx(1'b0, -40, 30);
    in_valid = 1'b1;
    r0_p2 = 8'sd60; r0_m2 = -8'sd60; r1_p2 = -8'sd20; r1_m2 = 8'sd20;
    model_step(1'b0, 60, -60, -20, 20);
    push_exp();
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    q.delete();
    model_init();
    chk("arst_vld", out_valid, 1'b0);
    chk("arst_pm", pm, PM_INIT);
    chk("arst_dec", dec, 4'b0);
    chk("arst_best", best_state, 2'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_idle_vld", out_valid, 1'b0);
    sym(1'b0, 8'sd100, -8'sd100, 8'sd100, -8'sd100);
    chk("arst_r25_pm", pm, PM_R25);
    chk("arst_r25_dec", dec, 4'b0000);
    chk("arst_r25_best", best_state, 2'd0);

    // Random stream against the exact-integer model.
    idle(1'b1);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0)
        idle(1'b0);
      else
        symx(($urandom_range(0, 49) == 0), int'($urandom_range(0, 80)) - 40,
             int'($urandom_range(0, 80)) - 40);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
